counter_seq_ctrl: RTL



---
 rtl/counter_pkg.sv | 16 +
 rtl/counter_seq_ctrl_btn_cond.sv | 69 ++++++
 rtl/counter_seq_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared constants for the counter run/stop sequencer: FSM state encoding,
// default datapath widths and the debounce counter width.
package counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam int DEF_PRESCALE_W = 25;
    localparam int DEF_CNT_W      = 3;
    localparam int DEB_W          = 20;

endpackage

// File: rtl/counter_seq_ctrl_btn_cond.sv
// Push-button conditioner: 2-flop synchronizer, optional debouncer
// (CTRL_DEBOUNCE_EN) and rising-edge detector giving a 1-cycle command pulse.
module btn_cond
    import counter_pkg::*;
(
    input  logic CLK,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;
    logic clean;

`ifdef CTRL_DEBOUNCE_EN
    logic             stable_q, stable_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

    // A new level is accepted only after 2^DEB_W consecutive differing samples.
    always_comb begin
        stable_d  = stable_q;
        deb_cnt_d = '0;
        if (sync2_q != stable_q) begin
            if (deb_cnt_q == '1) begin
                stable_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            stable_q  <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            stable_q  <= stable_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign clean = stable_q;
`else
    assign clean = sync2_q;
`endif

    always_comb begin
        sync1_d = i_btn;
        sync2_d = sync1_q;
        prev_d  = clean;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign o_pulse = clean & ~prev_q;

endmodule

// File: rtl/counter_seq_ctrl.sv
// Run/stop sequencer for the up/down counter datapath: button commands,
// prescaled count-enable tick, free-run and one-shot modes.
// Optional debounce on the buttons is enabled by defining CTRL_DEBOUNCE_EN.
module counter_seq_ctrl
    import counter_pkg::*;
#(
    parameter int PRESCALE_W = DEF_PRESCALE_W,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             iStart,
    input  logic             iStop,
    input  logic             iStep,
    input  logic             iClear,
    input  logic             iDir,
    input  logic             iMode,
    input  logic [CNT_W-1:0] iTarget,
    input  logic [CNT_W-1:0] iCount,
    output logic             oTick,
    output logic             oDir,
    output logic             oClr,
    output logic [1:0]       oState,
    output logic             oDone
);

    logic start_p, stop_p, step_p, clear_p;

    btn_cond u_start (.CLK(CLK), .rst_n(rst_n), .i_btn(iStart), .o_pulse(start_p));
    btn_cond u_stop  (.CLK(CLK), .rst_n(rst_n), .i_btn(iStop),  .o_pulse(stop_p));
    btn_cond u_step  (.CLK(CLK), .rst_n(rst_n), .i_btn(iStep),  .o_pulse(step_p));
    btn_cond u_clear (.CLK(CLK), .rst_n(rst_n), .i_btn(iClear), .o_pulse(clear_p));

    state_t                state_q, state_d;
    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic                  tick_q, tick_d;
    logic                  run_tick_q, run_tick_d;
    logic                  check_q, check_d;
    logic                  clr_q, clr_d;
    logic                  dir_q, dir_d;
    logic                  hit;
    logic                  wrap;

    // check_q marks the cycle after a RUN tick, when iCount already reflects it;
    // step ticks never set it, so they cannot end a one-shot.
    assign hit  = check_q && iMode && (iCount == iTarget);
    assign wrap = (pre_q == '1);

    always_comb begin
        state_d    = state_q;
        pre_d      = pre_q;
        tick_d     = 1'b0;
        run_tick_d = 1'b0;
        clr_d      = 1'b0;
        check_d    = run_tick_q;
        dir_d      = iDir;

        if (clear_p) begin
            clr_d   = 1'b1;
            pre_d   = '0;
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_p) begin
                        state_d = ST_RUN;
                        pre_d   = '0;
                    end else if (step_p) begin
                        tick_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    pre_d = pre_q + PRESCALE_W'(1);
                    if (wrap) begin
                        tick_d     = 1'b1;
                        run_tick_d = 1'b1;
                    end
                    if (stop_p) begin
                        state_d = ST_PAUSE;
                    end else if (hit) begin
                        state_d    = ST_DONE;
                        pre_d      = '0;
                        tick_d     = 1'b0;
                        run_tick_d = 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (start_p) begin
                        state_d = ST_RUN;
                    end else if (step_p) begin
                        tick_d = 1'b1;
                    end
                end
                ST_DONE: begin
                    pre_d = '0;
                    if (start_p) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    pre_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pre_q      <= '0;
            tick_q     <= 1'b0;
            run_tick_q <= 1'b0;
            check_q    <= 1'b0;
            clr_q      <= 1'b0;
            dir_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            tick_q     <= tick_d;
            run_tick_q <= run_tick_d;
            check_q    <= check_d;
            clr_q      <= clr_d;
            dir_q      <= dir_d;
        end
    end

    assign oTick  = tick_q;
    assign oDir   = dir_q;
    assign oClr   = clr_q;
    assign oState = state_q;
    assign oDone  = (state_q == ST_DONE);

endmodule
